// File: rtl/sc_io_pkg.sv
// Shared constants for the data-memory / memory-mapped I/O block.
// I/O register word offsets and the maximum port count.
package sc_io_pkg;

  localparam int IO_OFF_IN    = 0;
  localparam int IO_OFF_OUT   = 8;
  localparam int IO_OFF_CHG   = 16;
  localparam int IO_OFF_CYC   = 17;
  localparam int IO_OFF_MASK  = 18;
  localparam int IO_MAX_PORTS = 8;

endpackage

// File: rtl/sc_datamem_io_if.sv
// CPU data-access bus between the core and the data memory / I/O block.
// master = CPU side, slave = memory side.
interface sc_datamem_io_if;

  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        we;
  logic        re;

  modport master (
    output addr, datain, we, re,
    input  dataout
  );

  modport slave (
    input  addr, datain, we, re,
    output dataout
  );

endinterface

// File: rtl/io_in_sync.sv
// Two-flop synchroniser for one input port plus change detect.
// chg_o pulses for the cycle after a new synchronised value appears.
module io_in_sync #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] val_o,
  output logic         chg_o
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] s3_q, s3_d;

  always_comb begin
    s1_d = pin_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign val_o = s2_q;
  assign chg_o = (s2_q != s3_q);

endmodule

// File: rtl/sc_datamem_io.sv
// Data RAM plus memory-mapped I/O (inputs, outputs, CHG, CYCLE).
// IO_CHANGE_IRQ_EN adds a MASK register and a registered irq output.
module sc_datamem_io
  import sc_io_pkg::*;
#(
  parameter int MEM_AW = 5,
  parameter int N_IN   = 2,
  parameter int IN_W   = 5,
  parameter int N_OUT  = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  sc_datamem_io_if.slave        bus,
  input  logic [N_IN*IN_W-1:0]  in_port,
  output logic [N_OUT*32-1:0]   out_port
`ifdef IO_CHANGE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  logic              sel_io;
  logic [MEM_AW-1:0] word;
  logic [4:0]        off;
  logic              io_wr;
  logic              ram_we;

  assign sel_io = bus.addr[MEM_AW+2];
  assign word   = bus.addr[MEM_AW+1:2];
  assign off    = bus.addr[6:2];
  assign io_wr  = bus.we & sel_io;
  assign ram_we = bus.we & ~sel_io;

  logic unused_ok;
  assign unused_ok = ^{bus.addr[31:MEM_AW+3], bus.addr[1:0]};

  logic [IN_W-1:0] in_val [N_IN];
  logic [N_IN-1:0] in_chg;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    io_in_sync #(.W(IN_W)) u_sync (
      .clock  (clock),
      .resetn (resetn),
      .pin_i  (in_port[g*IN_W +: IN_W]),
      .val_o  (in_val[g]),
      .chg_o  (in_chg[g])
    );
  end

  logic [31:0] ram_q [2**MEM_AW];

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[word] <= bus.datain;
  end

  logic [31:0]     out_q [N_OUT];
  logic [31:0]     out_d [N_OUT];
  logic [N_IN-1:0] chg_q, chg_d, chg_clr;
  logic [31:0]     cyc_q, cyc_d;
`ifdef IO_CHANGE_IRQ_EN
  logic [N_IN-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
`endif

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (io_wr && off == 5'(IO_OFF_OUT + k)) out_d[k] = bus.datain;
    end
    chg_clr = '0;
    if (sel_io && off == 5'(IO_OFF_CHG)) begin
      if (bus.re) chg_clr = chg_q;
      if (bus.we) chg_clr = chg_clr | bus.datain[N_IN-1:0];
    end
    // a fresh change on the clearing edge survives
    chg_d = (chg_q & ~chg_clr) | in_chg;
    if (io_wr && off == 5'(IO_OFF_CYC)) cyc_d = bus.datain;
    else                                cyc_d = cyc_q + 32'd1;
`ifdef IO_CHANGE_IRQ_EN
    mask_d = mask_q;
    if (io_wr && off == 5'(IO_OFF_MASK)) mask_d = bus.datain[N_IN-1:0];
    irq_d = |(chg_q & mask_q);
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      chg_q <= '0;
      cyc_q <= '0;
`ifdef IO_CHANGE_IRQ_EN
      mask_q <= '0;
      irq_q  <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
      chg_q <= chg_d;
      cyc_q <= cyc_d;
`ifdef IO_CHANGE_IRQ_EN
      mask_q <= mask_d;
      irq_q  <= irq_d;
`endif
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_port[g*32 +: 32] = out_q[g];
  end

`ifdef IO_CHANGE_IRQ_EN
  assign irq = irq_q;
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (!sel_io) begin
      rdata = ram_q[word];
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (off == 5'(IO_OFF_IN + k)) rdata[IN_W-1:0] = in_val[k];
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (off == 5'(IO_OFF_OUT + k)) rdata = out_q[k];
      end
      if (off == 5'(IO_OFF_CHG)) rdata[N_IN-1:0] = chg_q;
      if (off == 5'(IO_OFF_CYC)) rdata = cyc_q;
`ifdef IO_CHANGE_IRQ_EN
      if (off == 5'(IO_OFF_MASK)) rdata[N_IN-1:0] = mask_q;
`endif
    end
  end

  assign bus.dataout = rdata;

endmodule

// File: tb/tb_sc_datamem_io.sv
// Randomised bench for sc_datamem_io against a behavioural model.
// Build with or without IO_CHANGE_IRQ_EN.
module tb_sc_datamem_io;

  localparam int MEM_AW = 5;
  localparam int N_IN   = 2;
  localparam int IN_W   = 5;
  localparam int N_OUT  = 3;
  localparam int PW     = N_IN*IN_W;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sc_datamem_io_if bus();
  logic [PW-1:0]       in_port;
  logic [N_OUT*32-1:0] out_port;
`ifdef IO_CHANGE_IRQ_EN
  logic irq;
`endif

  sc_datamem_io #(
    .MEM_AW(MEM_AW), .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port)
`ifdef IO_CHANGE_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  int nvec = 0;
  int nbad = 0;

  logic [31:0]   m_ram [32];
  bit            m_rv  [32];
  logic [31:0]   m_out [N_OUT];
  logic [N_IN-1:0] m_chg;
  logic [N_IN-1:0] m_mask;
  logic [31:0]   m_cyc;
  logic          m_irq;
  logic [PW-1:0] hist [$];
  logic [PW-1:0] pins;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    m_chg  = '0;
    m_mask = '0;
    m_cyc  = '0;
    m_irq  = 1'b0;
    hist.delete();
    repeat (3) hist.push_back('0);
  endtask

  // readable input value = pin value sampled two edges back
  function automatic logic [31:0] m_read(input logic [31:0] a,
                                         output bit known);
    int off;
    logic [PW-1:0] v;
    known = 1'b1;
    off = int'(a[6:2]);
    if (!a[7]) begin
      known = m_rv[a[6:2]];
      return m_ram[a[6:2]];
    end
    if (off < N_IN) begin
      v = hist[1];
      return 32'(v[off*IN_W +: IN_W]);
    end
    if (off >= 8 && off < 8 + N_OUT) return m_out[off-8];
    if (off == 16) return 32'(m_chg);
    if (off == 17) return m_cyc;
`ifdef IO_CHANGE_IRQ_EN
    if (off == 18) return 32'(m_mask);
`endif
    return 32'd0;
  endfunction

  function automatic logic [N_OUT*32-1:0] m_outv();
    logic [N_OUT*32-1:0] r;
    for (int k = 0; k < N_OUT; k++) r[k*32 +: 32] = m_out[k];
    return r;
  endfunction

  task automatic m_edge(input logic [31:0] a, d, input logic w, r,
                        input logic [PW-1:0] p);
    logic sel;
    int off;
    logic [N_IN-1:0] set, clr;
    logic [PW-1:0] now_v, old_v;
    sel = a[7];
    off = int'(a[6:2]);
    now_v = hist[1];
    old_v = hist[0];
    for (int k = 0; k < N_IN; k++)
      set[k] = (now_v[k*IN_W +: IN_W] != old_v[k*IN_W +: IN_W]);
    clr = '0;
    if (sel && off == 16) begin
      if (r) clr = m_chg;
      if (w) clr = clr | d[N_IN-1:0];
    end
`ifdef IO_CHANGE_IRQ_EN
    m_irq = |(m_chg & m_mask);
    if (sel && w && off == 18) m_mask = d[N_IN-1:0];
`endif
    m_chg = (m_chg & ~clr) | set;
    if (sel && w && off == 17) m_cyc = d;
    else                       m_cyc = m_cyc + 32'd1;
    if (sel && w && off >= 8 && off < 8 + N_OUT) m_out[off-8] = d;
    if (!sel && w) begin
      m_ram[a[6:2]] = d;
      m_rv[a[6:2]]  = 1'b1;
    end
    void'(hist.pop_front());
    hist.push_back(p);
  endtask

  task automatic cycle(input logic [31:0] a, d, input logic w, r,
                       output logic [31:0] rd);
    logic [31:0] exp;
    bit known;
    @(negedge clock);
    bus.addr   = a;
    bus.datain = d;
    bus.we     = w;
    bus.re     = r;
    in_port    = pins;
    #1;
    exp = m_read(a, known);
    rd  = bus.dataout;
    if (known) chk("dataout", rd, exp);
    @(posedge clock);
    m_edge(a, d, w, r, pins);
    #1;
    chk("out_port", out_port, m_outv());
`ifdef IO_CHANGE_IRQ_EN
    chk("irq", irq, m_irq);
`endif
  endtask

  logic [31:0] rd;
  int offs [11] = '{0, 1, 2, 8, 9, 10, 11, 16, 17, 18, 31};

  initial begin
    bus.addr = '0; bus.datain = '0; bus.we = 1'b0; bus.re = 1'b0;
    pins = '0; in_port = '0;
    for (int i = 0; i < 32; i++) m_rv[i] = 1'b0;
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out", out_port, 0);
    resetn = 1'b1;

    cycle(32'hC4, 0, 0, 0, rd);
    chk("cyc_first", rd, 32'd0);

    cycle(32'h7C, 32'hDEADBEEF, 1, 0, rd);
    cycle(32'h7C, 0, 0, 0, rd);
    chk("ram_7c", rd, 32'hDEADBEEF);
    cycle(32'h00, 32'hA5A5A5A5, 1, 0, rd);
    cycle(32'h80, 32'h11111111, 1, 0, rd);
    cycle(32'h00, 0, 0, 0, rd);
    chk("ram0_alias", rd, 32'hA5A5A5A5);

    cycle(32'hA0, 32'h12345678, 1, 0, rd);
    chk("out0_wr", out_port[31:0], 32'h12345678);
    cycle(32'hA0, 0, 0, 0, rd);
    chk("out0_rd", rd, 32'h12345678);

    pins[4:0] = 5'h15;
    cycle(32'h80, 0, 0, 0, rd);
    chk("sync_e0", rd, 32'h0);
    cycle(32'h80, 0, 0, 0, rd);
    chk("sync_e1", rd, 32'h0);
    cycle(32'h80, 0, 0, 0, rd);
    chk("sync_e2", rd, 32'h15);
    cycle(32'hC0, 0, 0, 0, rd);
    chk("chg_set", rd, 32'h1);
    cycle(32'hC0, 0, 0, 1, rd);
    chk("chg_rd1", rd, 32'h1);
    cycle(32'hC0, 0, 0, 0, rd);
    chk("chg_rd2", rd, 32'h0);

    pins[4:0] = 5'h0A;
    cycle(32'h80, 0, 0, 0, rd);
    pins[4:0] = 5'h1F;
    cycle(32'h80, 0, 0, 0, rd);
    cycle(32'hC0, 0, 0, 0, rd);
    chk("chg_pre", rd, 32'h0);
    cycle(32'hC0, 0, 0, 1, rd);
    chk("chg_setclr_a", rd, 32'h1);
    cycle(32'hC0, 0, 0, 1, rd);
    chk("chg_setclr_b", rd, 32'h1);
    cycle(32'hC0, 0, 0, 0, rd);
    chk("chg_setclr_c", rd, 32'h0);

    cycle(32'hC8, 32'h1, 1, 0, rd);
    cycle(32'hC8, 0, 0, 0, rd);
`ifdef IO_CHANGE_IRQ_EN
    chk("mask_rd", rd, 32'h1);
    pins[4:0] = 5'h04;
    cycle(32'h00, 0, 0, 0, rd);
    cycle(32'h00, 0, 0, 0, rd);
    cycle(32'h00, 0, 0, 0, rd);
    chk("irq_lag", irq, 1'b0);
    cycle(32'h00, 0, 0, 0, rd);
    chk("irq_hi", irq, 1'b1);
    cycle(32'hC0, 32'h1, 1, 0, rd);
    chk("irq_hold", irq, 1'b1);
    cycle(32'h00, 0, 0, 0, rd);
    chk("irq_lo", irq, 1'b0);
`else
    chk("mask_absent", rd, 32'h0);
`endif

    @(negedge clock);
    resetn = 1'b0;
    bus.addr = 32'hC4; bus.we = 1'b0; bus.re = 1'b0;
    #1;
    chk("rst_out", out_port, 0);
    chk("rst_cyc", bus.dataout, 32'h0);
`ifdef IO_CHANGE_IRQ_EN
    chk("rst_irq", irq, 1'b0);
`endif
    m_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (5) cycle(32'h00, 0, 0, 0, rd);
    cycle(32'hC4, 0, 0, 0, rd);
    chk("cyc_after_rst", rd, 32'd5);

    for (int n = 0; n < 600; n++) begin
      logic [7:0]  lo;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0, 1: lo = {1'b0, 5'($urandom), 2'($urandom)};
        2:    lo = {1'b1, 5'(offs[$urandom_range(0, 10)]), 2'($urandom)};
        default: lo = 8'($urandom);
      endcase
      a = {24'($urandom), lo};
      if ($urandom_range(0, 3) == 0) pins = PW'($urandom);
      cycle(a, $urandom, 1'($urandom), 1'($urandom), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
